bram_port_master: RTL and testbench

BRAM_PORT_MASTER -- requirements
Module: bram_port_master

---
 rtl/bram_port_master.sv | 90 +++++++++
 tb/tb_bram_port_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_master.sv
// Drives one BRAM port from a valid/ready request stream and returns read data
// in request order through a credit-guarded response FIFO.
module bram_port_master #(
    parameter int RSP_DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [14:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [14:0] addr,
    output logic [31:0] di,
    output logic [3:0]  we,
    output logic        en,
    input  logic [31:0] do_data
);
    localparam int PW  = $clog2(RSP_DEPTH);
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam logic [PW-1:0]  LAST_PTR = PW'(RSP_DEPTH - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(RSP_DEPTH);
    localparam logic [CW1-1:0] DEPTH_W  = CW1'(RSP_DEPTH);

    logic          inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   mem [RSP_DEPTH];

    logic           accept;
    logic           push;
    logic           pop;
    logic [CW1-1:0] credit_used;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both
    // high; ready never depends on the same-side valid nor on the opposite ready.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign req_ready   = rst_n & (credit_used < DEPTH_W);
    assign accept      = req_valid & req_ready;

    assign en   = accept;
    assign addr = req_addr;
    assign di   = req_wdata;
    assign we   = (accept & req_write) ? req_be : 4'b0000;

    assign rsp_valid = (count != '0);
    assign rsp_data  = mem[rd_ptr];

    // DO is only meaningful the cycle after a read was issued.
    assign push = inflight;
    assign pop  = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= accept & ~req_write;
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= do_data;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == FULL_CNT));

endmodule

// File: tb/tb_bram_port_master.sv
// Bench for bram_port_master: BRAM stub, transaction-level reference model with
// per-cycle compare, and directed scenarios with literal expectations.
module tb_bram_port_master;
    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [14:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [14:0] addr;
    logic [31:0] di;
    logic [3:0]  we;
    logic        en;
    logic [31:0] do_data;

    logic [31:0] bram    [32768];
    logic [31:0] ref_mem [32768];

    logic [31:0] exp_q[$];
    int          acc_q[$];
    logic [31:0] got_q[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rd_acc_cyc = 0;
    int   rise_cyc = 0;
    int   stall_cnt = 0;
    int   rd_cnt = 0;
    logic prev_valid = 1'b0;

    bram_port_master #(.RSP_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .addr      (addr),
        .di        (di),
        .we        (we),
        .en        (en),
        .do_data   (do_data)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // Read-first BRAM stub; DO is scrambled whenever the port is idle
    always @(posedge clk) begin
        if (en) begin
            do_data <= bram[addr];
            for (int b = 0; b < 4; b++) begin
                if (we[b]) bram[addr][8*b +: 8] = di[8*b +: 8];
            end
        end else begin
            do_data <= $urandom();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model + per-cycle compare
    always @(negedge clk) begin
        logic exp_ready;
        logic exp_valid;
        logic exp_en;
        exp_ready = rst_n && (exp_q.size() < DEPTH);
        exp_valid = rst_n && (exp_q.size() > 0) && (acc_q[0] <= cyc - 2);
        exp_en    = req_valid && exp_ready;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        check("en", 32'(en), 32'(exp_en));
        check("we", 32'(we), (exp_en && req_write) ? 32'(req_be) : 32'd0);
        if (exp_en) begin
            check("addr", 32'(addr), 32'(req_addr));
            check("di", di, req_wdata);
        end
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (exp_valid) check("rsp_data", rsp_data, exp_q[0]);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got 0x%08h, expected no response (cycle %0d)",
                             rsp_data, cyc);
                end else begin
                    got_q.push_back(rsp_data);
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
            end
            if (rsp_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = rsp_valid;
            if (req_valid && !req_ready) stall_cnt++;
            if (req_valid && req_ready) begin
                if (req_write) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_be[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                    end
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                    acc_q.push_back(cyc);
                    rd_acc_cyc = cyc;
                    rd_cnt++;
                end
            end
        end
    end

    // Driver tasks (called 1 ns after a rising edge)
    task automatic issue(input logic wr, input logic [14:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        logic ok;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("issue_accepted", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] init_word(input int a);
        return 32'hC0DE_0000 ^ 32'(a);
    endfunction

    initial begin
        int c0;
        int s0;
        int r0;
        int n_acc;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 32768; i++) begin
            bram[i]    = init_word(i);
            ref_mem[i] = init_word(i);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Full write then read-back with two-cycle latency
        got_q.delete();
        issue(1'b1, 15'h0010, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 15'h0010, 32'h0, 4'h0);
        drain();
        check("t037_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("t037_data", got_q[0], 32'hDEADBEEF);
        check("t037_latency", 32'(rise_cyc - rd_acc_cyc), 32'd2);

        // Byte enables, and a zero-BE write that must not change memory
        got_q.delete();
        issue(1'b1, 15'h0020, 32'hFFFFFFFF, 4'hF);
        issue(1'b1, 15'h0020, 32'h00000000, 4'b0101);
        issue(1'b0, 15'h0020, 32'h0, 4'h0);
        issue(1'b1, 15'h0020, 32'h12345678, 4'b0000);
        issue(1'b0, 15'h0020, 32'h0, 4'h0);
        drain();
        check("t038_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() > 1) begin
            check("t038_be_merge", got_q[0], 32'hFF00FF00);
            check("t038_be_zero", got_q[1], 32'hFF00FF00);
        end

        // 16 back-to-back reads at full rate
        got_q.delete();
        s0 = stall_cnt;
        c0 = cyc;
        for (int i = 0; i < 16; i++) issue(1'b0, 15'(32'h100 + i), 32'h0, 4'h0);
        check("t039_cycles", 32'(cyc - c0), 32'd16);
        check("t039_no_stall", 32'(stall_cnt - s0), 32'd0);
        drain();
        check("t039_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            check("t039_order", got_q[i], init_word(32'h100 + i));

        // Backpressure: credits stop exactly at DEPTH, then drain in order
        got_q.delete();
        rsp_ready = 1'b0;
        n_acc = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        for (int t = 0; t < 10; t++) begin
            req_addr = 15'(32'h200 + n_acc);
            @(negedge clk);
            if (req_ready) n_acc++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("t040_accepted", 32'(n_acc), 32'd3);
        @(negedge clk);
        check("t040_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();
        check("t040_count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < got_q.size(); i++)
            check("t040_order", got_q[i], init_word(32'h200 + i));

        // Reset with two buffered responses and one read in flight
        got_q.delete();
        rsp_ready = 1'b0;
        issue(1'b0, 15'h0300, 32'h0, 4'h0);
        issue(1'b0, 15'h0301, 32'h0, 4'h0);
        issue(1'b0, 15'h0302, 32'h0, 4'h0);
        check("t041_valid_before", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t041_valid_in_reset", 32'(rsp_valid), 32'd0);
        check("t041_ready_in_reset", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t041_no_stale", 32'(got_q.size()), 32'd0);
        issue(1'b0, 15'h0303, 32'h0, 4'h0);
        drain();
        check("t041_post_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("t041_post_data", got_q[0], init_word(32'h303));

        // Random valid/ready/write mix over a small address window
        got_q.delete();
        r0 = rd_cnt;
        for (int t = 0; t < 300; t++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 15'($urandom_range(0, 7));
            req_wdata = $urandom();
            req_be    = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        check("t042_rsp_count", 32'(got_q.size()), 32'(rd_cnt - r0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
